// File: rtl/alu_pkg.sv
// Shared types and constants for the alu and its request arbiter.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLG_W  = 4;

  // Op codes are carried through the arbiter undecoded; only the alu interprets them.
  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;

  // Bit positions inside the {N, Z, C, V} flag nibble.
  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [FLG_W-1:0]  flags;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bus of the alu arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_res;
  logic [FLG_W-1:0]        rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan N positions starting one past the previous winner.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational alu between N_REQ requesters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [FLG_W-1:0]  alu_flags,
  output logic              busy
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_any;
  logic             load;
  logic             rsp_done;
  alu_req_t         pick_req;
  alu_req_t         cur_req;
  alu_rsp_t         cur_rsp;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Payload of the requester that would win this cycle.
  always_comb begin
    pick_req.a  = bus.req_a[DATA_W*32'(pick_idx) +: DATA_W];
    pick_req.b  = bus.req_b[DATA_W*32'(pick_idx) +: DATA_W];
    pick_req.op = bus.req_op[OP_W*32'(pick_idx) +: OP_W];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: one grant, one settle cycle, then wait for the response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: accept strobe only while idle; only the granted requester can retire the response.
  always_comb begin
    bus.req_ready = '0;
    load          = 1'b0;
    rsp_done      = 1'b0;
    if (state == IDLE) begin
      bus.req_ready = pick_onehot;
      load          = pick_any;
    end
    if (state == RESP) rsp_done = bus.rsp_ready[grant_idx];
  end

  // Operand, result and pointer registers around the shared alu.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_req       <= '0;
      cur_rsp       <= '0;
      grant_idx     <= '0;
      last_grant    <= IDX_W'(N_REQ - 1);
      bus.rsp_valid <= '0;
      busy          <= 1'b0;
    end else begin
      if (load) begin
        cur_req   <= pick_req;
        grant_idx <= pick_idx;
      end
      if (state == EXEC) begin
        cur_rsp.res   <= alu_res;
        cur_rsp.flags <= alu_flags;
        bus.rsp_valid <= N_REQ'(1) << grant_idx;
      end else if (rsp_done) begin
        bus.rsp_valid <= '0;
        last_grant    <= grant_idx;
      end
      busy <= (state_nxt != IDLE);
    end
  end

  assign alu_a         = cur_req.a;
  assign alu_b         = cur_req.b;
  assign alu_op        = cur_req.op;
  assign bus.rsp_res   = cur_rsp.res;
  assign bus.rsp_flags = cur_rsp.flags;

endmodule
